serial_adder_param: RTL and testbench
=====================================

// Module: serial_adder_param
// PURPOSE
// - Parametrised bit-serial adder/subtractor. It shifts in two WIDTH-bit operands one bit per clock
//   and computes a WIDTH+1-bit result. The result is shifted back out serially, with en_o framing
//   every valid output bit.
// - Sits between serial stimulus/link logic and serial consumers. It replaces the fixed 2-bit add-only adder.
// PARAMETERS
// - WIDTH          2   operand width in bits (>=1); result is WIDTH+1 bits
// - LSB_FIRST      0   0: operands and result are MSB-first; 1: LSB-first (applies to both directions)
// PORTS
// - clk     in   1   single clock, all logic on rising edge
// - rst_n   in   1   synchronous, active-low reset
// - en_i    in   1   start strobe; in the start cycle the first operand bits are also sampled
// - mode_i  in   1   0 = a+b, 1 = a-b; sampled only in the start cycle
// - ina     in   1   serial operand A bit
// - inb     in   1   serial operand B bit
// - en_o    out  1   high while out carries a valid result bit
// - out     out  1   serial result bit
// - busy_o  out  1   high whenever state != IDLE
// - err_o   out  1   one-cycle pulse: en_i was asserted while busy; that start request is dropped
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state=IDLE; counters and shift registers cleared; en_o=0, out=0, busy_o=0, err_o=0.
//   - Reset mid-frame discards the partial operation; no result bits are emitted.
// - Registered outputs: en_o, out, err_o. busy_o is decoded from the state register.
// - FSM states IDLE -> SAMPLE -> SHIFT_OUT -> IDLE.
// - Cycle 0 is the cycle with en_i=1 while in IDLE:
//   - ina/inb/mode_i are captured and the bit counter is set to 1.
//   - The state becomes SAMPLE. If WIDTH=1, the state goes directly to the compute edge.
// - SAMPLE: one bit of ina/inb is captured per cycle, in cycles 0..WIDTH-1.
//   - en_i in these cycles is ignored for the data path and raises err_o.
// - Compute edge (end of cycle WIDTH-1):
//   - add: res = {1'b0,a} + {1'b0,b}.
//   - sub: res = {1'b0,a} - {1'b0,b}, mod 2^(WIDTH+1). res[WIDTH] is the borrow/sign bit.
//   - res is loaded into the output shift register.
//   - The first result bit (MSB, or LSB if LSB_FIRST) is driven on out, and en_o=1.
// - SHIFT_OUT: en_o=1 during cycles WIDTH..2*WIDTH inclusive (exactly WIDTH+1 cycles), with one result bit per cycle.
// - Edge at end of cycle 2*WIDTH: en_o=0, out=0, state=IDLE.
//   - en_i in cycle 2*WIDTH is still "busy" and raises err_o.
//   - The earliest accepted restart is cycle 2*WIDTH+1.
// - out is 0 whenever en_o=0.
// - ina/inb are don't-care outside sampling cycles.
// - Latency: the first result bit appears WIDTH cycles after cycle 0; a frame is 2*WIDTH+1 cycles.
// - err_o does not alter the state, counters, or the in-flight result.
// - Bit counter width is $clog2(WIDTH+2).
// - The counter never wraps within a frame and is cleared on return to IDLE.
// STRUCTURE
// - serial_adder_pkg:
//   - state_t enum {IDLE, SAMPLE, SHIFT_OUT}
//   - localparams MODE_ADD=1'b0, MODE_SUB=1'b1
// - Sub-module serial_piso_shreg #(W, LSB_FIRST): parallel load, shift enable, serial bit out.
//   - It is instantiated for the result path.
//   - Operand capture uses inline SIPO shift registers.
// TESTING (WIDTH=4, LSB_FIRST=0 unless stated)
// - Add: a=1011, b=0110, mode=0
//   -> en_o high in cycles 4..8, out = 1,0,0,0,1 (17); busy_o low from cycle 9.
// - Sub: a=0110, b=1011, mode=1 -> out = 1,1,0,1,1 (-5 as 5-bit two's complement).
// - Max: a=b=1111 add -> out = 1,1,1,1,0 (30). a=b=0000 sub -> out = 0,0,0,0,0 with en_o still framed for 5 cycles.
// - Protocol:
//   - en_i pulsed in cycle 2 and in cycle 8 -> err_o pulses in cycles 3 and 9; result unchanged.
//   - en_i in cycle 9 -> new frame accepted, no err_o.
// - Reset: rst_n=0 in cycle 5 (mid SHIFT_OUT) -> en_o/out/busy_o=0 from cycle 6; the next en_i starts a clean frame.
// - LSB_FIRST=1, WIDTH=1: a=1, b=1 add -> en_o in cycles 1..2, out = 0,1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAMPLE    = 2'd1,
        SHIFT_OUT = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_pkg

// File: rtl/serial_piso_shreg.sv
// Parallel-in serial-out shift register; zeros are shifted in behind the data
// so the serial output idles low once the word has drained.
module serial_piso_shreg #(
    parameter int W         = 3,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] shreg_r;

    // Parallel load has priority over shifting; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            if (LSB_FIRST) begin
                shreg_r <= shreg_r >> 1'b1;
            end else begin
                shreg_r <= shreg_r << 1'b1;
            end
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign sout = LSB_FIRST ? shreg_r[0] : shreg_r[W-1];

endmodule : serial_piso_shreg

// File: rtl/serial_adder_param.sv
// Bit-serial adder/subtractor: samples WIDTH operand bits, then streams the
// WIDTH+1-bit sum or difference back out framed by en_o.
module serial_adder_param
    import serial_adder_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic mode_i,
    input  logic ina,
    input  logic inb,
    output logic en_o,
    output logic out,
    output logic busy_o,
    output logic err_o
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int RES_W = WIDTH + 1;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   a_r, b_r, a_nxt_s, b_nxt_s;
    logic               mode_r, mode_s;
    logic               cap_s, compute_s, shift_s;
    logic [RES_W-1:0]   res_s;
    logic               en_r, err_r;

    // Operand SIPO next value: the incoming bit enters at the end the stream starts from.
    always_comb begin
        a_nxt_s = a_r;
        b_nxt_s = b_r;
        if (LSB_FIRST) begin
            a_nxt_s            = a_r >> 1'b1;
            b_nxt_s            = b_r >> 1'b1;
            a_nxt_s[WIDTH-1]   = ina;
            b_nxt_s[WIDTH-1]   = inb;
        end else begin
            a_nxt_s            = a_r << 1'b1;
            b_nxt_s            = b_r << 1'b1;
            a_nxt_s[0]         = ina;
            b_nxt_s[0]         = inb;
        end
    end

    // Mode comes straight from the pin in the start cycle so WIDTH=1 computes immediately.
    always_comb begin
        mode_s = mode_r;
        res_s  = '0;
        if (state_r == IDLE) begin
            mode_s = mode_i;
        end else begin
            mode_s = mode_r;
        end
        if (mode_s == MODE_SUB) begin
            res_s = {1'b0, a_nxt_s} - {1'b0, b_nxt_s};
        end else begin
            res_s = {1'b0, a_nxt_s} + {1'b0, b_nxt_s};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cap_s       = 1'b0;
        compute_s   = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (en_i) begin
                    cap_s = 1'b1;
                    if (WIDTH == 1) begin
                        compute_s   = 1'b1;
                        state_nxt_s = SHIFT_OUT;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = SAMPLE;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            SAMPLE: begin
                cap_s = 1'b1;
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    compute_s   = 1'b1;
                    state_nxt_s = SHIFT_OUT;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            SHIFT_OUT: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_W'(WIDTH)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter, operand capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            mode_r  <= MODE_ADD;
            en_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (cap_s) begin
                a_r <= a_nxt_s;
                b_r <= b_nxt_s;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
            end
            if ((state_r == IDLE) && en_i) begin
                mode_r <= mode_i;
            end else begin
                mode_r <= mode_r;
            end
            en_r  <= (state_nxt_s == SHIFT_OUT);
            err_r <= en_i && (state_r != IDLE);
        end
    end

    serial_piso_shreg #(
        .W         (RES_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_res_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (compute_s),
        .shift (shift_s),
        .din   (res_s),
        .sout  (out)
    );

    assign en_o   = en_r;
    assign err_o  = err_r;
    assign busy_o = (state_r != IDLE);

endmodule : serial_adder_param

// File: tb/tb_serial_adder_param.sv
// Scoreboard bench for serial_adder_param: WIDTH=4 MSB-first and WIDTH=1 LSB-first instances.
module tb_serial_adder_param;

    typedef struct {
        int   cyc;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en4, mode4, ina4, inb4, eo4, out4, busy4, err4;
    logic en1, mode1, ina1, inb1, eo1, out1, busy1, err1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 1'b0;
    exp_t q4[$];
    exp_t q1[$];
    int   err_q[$];

    always #5 clk = ~clk;

    // Cycle index: stimulus applied after an edge belongs to cycle cyc.
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_param #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .en_i(en4), .mode_i(mode4), .ina(ina4), .inb(inb4),
        .en_o(eo4), .out(out4), .busy_o(busy4), .err_o(err4)
    );

    serial_adder_param #(.WIDTH(1), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en1), .mode_i(mode1), .ina(ina1), .inb(inb1),
        .en_o(eo1), .out(out1), .busy_o(busy1), .err_o(err1)
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expected result bits and error pulses, otherwise requires idle outputs.
    always @(negedge clk) begin
        if (mon_on) begin
            if (q4.size() > 0 && q4[0].cyc == cyc) begin
                chk(eo4 === 1'b1 && out4 === q4[0].b, "w4_bit", {eo4, out4}, {1'b1, q4[0].b});
                void'(q4.pop_front());
            end else begin
                chk(eo4 === 1'b0 && out4 === 1'b0, "w4_idle_out", {eo4, out4}, 0);
            end
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                chk(eo1 === 1'b1 && out1 === q1[0].b, "w1_bit", {eo1, out1}, {1'b1, q1[0].b});
                void'(q1.pop_front());
            end else begin
                chk(eo1 === 1'b0 && out1 === 1'b0, "w1_idle_out", {eo1, out1}, 0);
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                chk(err4 === 1'b1, "w4_err_pulse", err4, 1);
                void'(err_q.pop_front());
            end else begin
                chk(err4 === 1'b0, "w4_err_idle", err4, 0);
            end
            chk(err1 === 1'b0, "w1_err_idle", err1, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 frame of 9 cycles; rst_off >= 0 pulls reset in that relative cycle.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic mode,
                        input logic [4:0] res, input bit p2, input bit p8, input int rst_off);
        int c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            if (rst_off < 0 || 4 + k <= rst_off) q4.push_back('{c0 + 4 + k, res[4-k]});
        end
        if (p2) err_q.push_back(c0 + 3);
        if (p8) err_q.push_back(c0 + 9);
        for (int i = 0; i < 9; i++) begin
            en4   = (i == 0) || (p2 && i == 2) || (p8 && i == 8);
            ina4  = (i < 4) ? a[3-i] : 1'($urandom);
            inb4  = (i < 4) ? b[3-i] : 1'($urandom);
            mode4 = (i == 0) ? mode : 1'($urandom);
            rst_n = (i == rst_off) ? 1'b0 : 1'b1;
            if (i == 1) chk(busy4 === 1'b1, "w4_busy_in_frame", busy4, 1);
            step();
        end
        en4   = 1'b0;
        rst_n = 1'b1;
        chk(busy4 === 1'b0, "w4_busy_after_frame", busy4, 0);
    endtask

    // One WIDTH=1 LSB-first frame of 3 cycles; res is the 2-bit result.
    task automatic run1(input logic a, input logic b, input logic mode, input logic [1:0] res);
        int c0 = cyc;
        q1.push_back('{c0 + 1, res[0]});
        q1.push_back('{c0 + 2, res[1]});
        for (int i = 0; i < 3; i++) begin
            en1   = (i == 0);
            ina1  = (i == 0) ? a : 1'($urandom);
            inb1  = (i == 0) ? b : 1'($urandom);
            mode1 = (i == 0) ? mode : 1'($urandom);
            step();
        end
        en1 = 1'b0;
        chk(busy1 === 1'b0, "w1_busy_after_frame", busy1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {en4, mode4, ina4, inb4} = 4'b0000;
        {en1, mode1, ina1, inb1} = 4'b0000;
        repeat (3) step();
        mon_on = 1'b1;
        chk(busy4 === 1'b0, "w4_reset_busy", busy4, 0);
        chk(busy1 === 1'b0, "w1_reset_busy", busy1, 0);
        rst_n = 1'b1;
        step();

        run1(1'b1, 1'b1, 1'b0, 2'b10);
        run1(1'b0, 1'b1, 1'b1, 2'b11);
        step();

        run4(4'b1011, 4'b0110, 1'b0, 5'b10001, 1'b0, 1'b0, -1);
        step();
        run4(4'b0110, 4'b1011, 1'b1, 5'b11011, 1'b1, 1'b1, -1);
        run4(4'b1111, 4'b1111, 1'b0, 5'b11110, 1'b0, 1'b0, -1);
        step();
        run4(4'b0000, 4'b0000, 1'b1, 5'b00000, 1'b0, 1'b0, -1);
        step();
        run4(4'b1011, 4'b0110, 1'b0, 5'b10001, 1'b0, 1'b0, 5);
        run4(4'b0101, 4'b0011, 1'b0, 5'b01000, 1'b0, 1'b0, -1);

        repeat (4) step();
        chk(q4.size() == 0, "w4_queue_drained", q4.size(), 0);
        chk(q1.size() == 0, "w1_queue_drained", q1.size(), 0);
        chk(err_q.size() == 0, "err_queue_drained", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule : tb_serial_adder_param
